// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared constants for the round-robin decoder arbiter:
//   ST_IDLE / ST_GRANT : two-state FSM encoding
//   NUM_REQ            : number of requesters (4)
//   IDX_W              : width of a requester index (2)
// ---------------------------------------------------------------------------
package arb_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;

endpackage

// File: rtl/onehot_dec2.sv
// ---------------------------------------------------------------------------
// onehot_dec2
// Combinational 2-to-4 decoder with enable.
// Ports:
//   en     in   1  decoder enable; output is all-zero when low
//   idx    in   2  index to decode
//   onehot out  4  (1 << idx) when en=1, else 4'b0000
// ---------------------------------------------------------------------------
module onehot_dec2
   import arb_pkg::*;
(
   input  logic               en,
   input  logic [IDX_W-1:0]   idx,
   output logic [NUM_REQ-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) begin
         onehot[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/rr_decoder_arbiter.sv
// ---------------------------------------------------------------------------
// rr_decoder_arbiter
// Round-robin arbiter sharing one resource among 4 requesters. The winner
// is registered as (gnt_valid, gnt_idx) and then decoded to a one-hot
// grant, so the one-hot output never sees a combinational path from req.
//
// Parameters:
//   MAX_HOLD  max consecutive grant cycles (0 = no timeout)
//   CNT_W     hold counter width, 2^CNT_W > MAX_HOLD
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   lock       in   1  (only with ARB_LOCK_EN) suppress the hold timeout
//   req        in   4  request lines, bit i = requester i
//   gnt_valid  out  1  a grant is active this cycle
//   gnt_idx    out  2  granted requester (valid only with gnt_valid)
//   gnt_onehot out  4  decoded grant, zero when no grant
//   timeout    out  1  one-cycle pulse after a forced release
// Configuration macro: ARB_LOCK_EN adds the lock input.
//
// Handshake: a requester holds req[i] high until it is done; the cycle after
// it drops req[i] while granted, the grant is released and one idle bubble
// cycle follows before any new grant.
// ---------------------------------------------------------------------------
module rr_decoder_arbiter
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
)(
   input  logic               clk,
   input  logic               rst_n,
`ifdef ARB_LOCK_EN
   input  logic               lock,
`endif
   input  logic [NUM_REQ-1:0] req,
   output logic               gnt_valid,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic [NUM_REQ-1:0] gnt_onehot,
   output logic               timeout
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   logic [0:0]       state;
   logic [IDX_W-1:0] ptr;
   logic [CNT_W-1:0] hold_cnt;
   logic             hold_limit;
   logic             lock_on;

   // First set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4). The loop runs
   // from the farthest offset down so the nearest hit overwrites last.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [IDX_W-1:0]   p);
      logic [IDX_W-1:0] cand;
      rr_pick = p;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = p + IDX_W'(k);
         if (r[cand]) begin
            rr_pick = cand;
         end
      end
   endfunction

`ifdef ARB_LOCK_EN
   assign lock_on = lock;
`else
   assign lock_on = 1'b0;
`endif

   assign hold_limit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
   assign gnt_valid  = (state == ST_GRANT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         ptr      <= '0;
         gnt_idx  <= '0;
         hold_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         timeout <= 1'b0;
         if (state == ST_IDLE) begin
            if (|req) begin
               gnt_idx  <= rr_pick(req, ptr);
               hold_cnt <= '0;
               state    <= ST_GRANT;
            end
         end else begin
            if (!req[gnt_idx]) begin
               ptr   <= gnt_idx + IDX_W'(1);
               state <= ST_IDLE;
            end else if (hold_limit && !lock_on) begin
               ptr     <= gnt_idx + IDX_W'(1);
               state   <= ST_IDLE;
               timeout <= 1'b1;
            end else if (!hold_limit) begin
               hold_cnt <= hold_cnt + CNT_W'(1);
            end
            // hold_limit with lock_on: counter saturates, grant is held
         end
      end
   end

   onehot_dec2 u_dec (
      .en     (gnt_valid),
      .idx    (gnt_idx),
      .onehot (gnt_onehot)
   );

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_decoder_arbiter
// Self-checking bench: a behavioural model predicts the outputs after each
// clock edge; predictions go into exp_q when the stimulus is driven and are
// popped and compared once the DUT has clocked. A second queue holds the
// expected order of new grants for the directed rotation/wrap sequences.
// ---------------------------------------------------------------------------
module tb_rr_decoder_arbiter;

   localparam int MAX_HOLD = 8;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic       gnt_valid;
   logic [1:0] gnt_idx;
   logic [3:0] gnt_onehot;
   logic       timeout;
`ifdef ARB_LOCK_EN
   logic       lock;
`endif

   int total = 0;
   int bad   = 0;

   logic [7:0] exp_q[$];
   int         ord_q[$];

   // model state
   bit m_valid, m_to;
   int m_idx, m_ptr, m_cnt;
   bit prev_valid;
   int to_seen;

   rr_decoder_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef ARB_LOCK_EN
      .lock       (lock),
`endif
      .req        (req),
      .gnt_valid  (gnt_valid),
      .gnt_idx    (gnt_idx),
      .gnt_onehot (gnt_onehot),
      .timeout    (timeout)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_to = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
   endtask

   // behavioural prediction of one clock edge
   task automatic model_edge(input logic [3:0] r, input bit lk);
      bit found;
      m_to = 0;
      if (!m_valid) begin
         found = 0;
         for (int k = 0; k < 4; k++) begin
            if (!found && r[(m_ptr + k) % 4]) begin
               m_idx = (m_ptr + k) % 4;
               found = 1;
            end
         end
         if (found) begin
            m_valid = 1;
            m_cnt   = 0;
         end
      end else if (!r[m_idx]) begin
         m_ptr   = (m_idx + 1) % 4;
         m_valid = 0;
      end else if (MAX_HOLD != 0 && m_cnt == MAX_HOLD - 1 && !lk) begin
         m_ptr   = (m_idx + 1) % 4;
         m_valid = 0;
         m_to    = 1;
      end else if (!(MAX_HOLD != 0 && m_cnt == MAX_HOLD - 1)) begin
         m_cnt++;
      end
   endtask

   function automatic logic [7:0] model_vec();
      logic [3:0] oh;
      logic [1:0] ix;
      oh = m_valid ? (4'b0001 << m_idx) : 4'b0000;
      ix = m_valid ? 2'(m_idx) : 2'b00;
      return {m_to, m_valid, ix, oh};
   endfunction

   // driver: one cycle of stimulus, prediction, and comparison
   task automatic step(input logic [3:0] r);
      logic [7:0] e;
      logic [7:0] o;
      bit lk;
      @(negedge clk);
      req = r;
`ifdef ARB_LOCK_EN
      lk = lock;
`else
      lk = 0;
`endif
      model_edge(r, lk);
      exp_q.push_back(model_vec());
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      o = {timeout, gnt_valid, (e[6] ? gnt_idx : 2'b00), gnt_onehot};
      check("cycle", 32'(o), 32'(e));
      if (timeout) to_seen++;
      if (gnt_valid && !prev_valid && ord_q.size() > 0) begin
         check("grant_order", 32'(gnt_idx), 32'(ord_q.pop_front()));
      end
      prev_valid = gnt_valid;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      req   = 4'b0000;
      model_reset();
      prev_valid = 0;
      @(negedge clk);
      rst_n = 1;
   endtask

   initial begin
      logic [3:0] r;
      rst_n = 0;
      req   = 4'b0000;
`ifdef ARB_LOCK_EN
      lock  = 1'b0;
`endif
      model_reset();
      prev_valid = 0;
      to_seen = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", {27'd0, timeout, gnt_valid, gnt_idx, gnt_onehot}, 32'd0);
      @(negedge clk);
      rst_n = 1;

      // wrap/skip: 0101 -> grants 0, 2, 0 (last one wraps from ptr=3)
      ord_q = '{0, 2, 0};
      step(4'b0101);
      check("wrap_oh0", 32'(gnt_onehot), 32'h1);
      step(4'b0100);
      step(4'b0101);
      check("wrap_oh2", 32'(gnt_onehot), 32'h4);
      step(4'b0001);
      step(4'b0101);
      check("wrap_oh0b", 32'(gnt_onehot), 32'h1);
      check("wrap_left", 32'(ord_q.size()), 32'd0);

      // rotation: all request, each drops 2 cycles after its grant
      do_reset();
      ord_q = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 16; i++) begin
         r = 4'b1111;
         if (m_valid && m_cnt == 1) r[m_idx] = 1'b0;
         step(r);
      end
      check("rot_left", 32'(ord_q.size()), 32'd0);

      // asynchronous reset in the middle of a grant
      do_reset();
      step(4'b1111);
      step(4'b1111);
      @(negedge clk);
      #2;
      rst_n = 0;
      #1;
      check("arst_valid", 32'(gnt_valid), 32'd0);
      check("arst_onehot", 32'(gnt_onehot), 32'd0);
      model_reset();
      prev_valid = 0;
      @(negedge clk);
      rst_n = 1;
      ord_q = '{0};
      step(4'b1111);
      check("arst_left", 32'(ord_q.size()), 32'd0);

      // timeout: req[1] alone -> 8 grant cycles, pulse, bubble, regrant
      do_reset();
      to_seen = 0;
      ord_q = '{1, 1, 1};
      repeat (20) step(4'b0010);
      check("to_count", 32'(to_seen), 32'd2);
      check("to_left", 32'(ord_q.size()), 32'd0);

      // random traffic
      do_reset();
      r = 4'b0000;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
         step(r);
      end

`ifdef ARB_LOCK_EN
      // lock holds the grant past MAX_HOLD; dropping it forces release
      do_reset();
      to_seen = 0;
      lock = 1'b1;
      repeat (20) step(4'b1000);
      check("lock_no_to", 32'(to_seen), 32'd0);
      check("lock_held", 32'(gnt_onehot), 32'h8);
      lock = 1'b0;
      step(4'b1000);
      check("lock_release", {30'd0, timeout, gnt_valid}, 32'h2);
`endif

      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // global bound so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: got=running want=finished");
      $fatal(1);
   end

endmodule
